weight_packer: RTL and testbench
================================

WEIGHT_PACKER -- requirements
Module: weight_packer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, meaning bits per weight byte lane.
REQ-002 SHALL have parameter DATA_LENGTH, default 8, meaning lanes per scratchpad word.
REQ-003 SHALL have parameter SPAD_DATA_WIDTH, default 64, meaning scratchpad word width; SHALL equal DATA_WIDTH*DATA_LENGTH.
REQ-004 SHALL have parameter ADDR_WIDTH, default 8, meaning scratchpad address width.
REQ-005 SHALL have localparam CNT_WIDTH = ADDR_WIDTH + $clog2(DATA_LENGTH), meaning byte-count width.
REQ-006 i_clk  input  1  clock, all state on rising edge.
REQ-007 i_nrst  input  1  reset, asynchronous, active-low.
REQ-008 i_clear  input  1  synchronous abort to IDLE.
REQ-009 i_start  input  1  begin a load; sampled only in IDLE or DONE.
REQ-010 i_base_addr  input  ADDR_WIDTH  first scratchpad word address, latched on start.
REQ-011 i_byte_count  input  CNT_WIDTH  weight bytes in this load, latched on start.
REQ-012 i_valid  input  1  upstream byte valid.
REQ-013 i_data  input  DATA_WIDTH  upstream weight byte.
REQ-014 o_ready  output  1  packer accepts a byte this cycle.
REQ-015 o_spad_write_en  output  1  one-cycle scratchpad write strobe.
REQ-016 o_spad_write_addr  output  ADDR_WIDTH  scratchpad write address.
REQ-017 o_spad_data  output  SPAD_DATA_WIDTH  packed scratchpad word.
REQ-018 o_busy  output  1  high in FILL or FLUSH.
REQ-019 o_done  output  1  sticky load-complete flag.
REQ-020 o_words_written  output  ADDR_WIDTH+1  words written by current/last load.

Function
REQ-021 FSM states SHALL be IDLE, FILL, FLUSH, DONE.
REQ-022 IDLE/DONE + i_start: byte_count>0 -> FILL, latch base/count, zero lane index, byte counter, word counter, pack register, clear o_done; byte_count==0 -> DONE with no write.
REQ-023 i_start in FILL or FLUSH SHALL be ignored.
REQ-024 o_ready SHALL be 1 only in FILL, combinational from state; byte accepted when i_valid & o_ready.
REQ-025 Accepted byte SHALL be placed in lane[lane_idx] = bits [lane_idx*DATA_WIDTH +: DATA_WIDTH]; first byte of a word in lane 0.
REQ-026 Word SHALL complete when lane_idx==DATA_LENGTH-1 or the accepted byte is the final one (byte counter == count-1).
REQ-027 On completion: next cycle o_spad_write_en=1, o_spad_data=pack register merged with completing byte, unused lanes of a final partial word zero, o_spad_write_addr=(base + word index) mod 2^ADDR_WIDTH; pack register and lane_idx cleared same edge.
REQ-028 Write latency SHALL be exactly 1 cycle after the completing byte's acceptance; back-to-back full words SHALL sustain 1 byte/cycle with no bubble.
REQ-029 o_words_written SHALL increment on the edge that asserts o_spad_write_en.
REQ-030 Final byte accepted -> FLUSH (final write pulse occurs in FLUSH, o_ready=0) -> DONE next cycle, o_done=1.
REQ-031 o_done SHALL stay 1 in DONE until i_start or i_clear; o_words_written SHALL hold.
REQ-032 i_valid low in FILL SHALL stall with no state change.
REQ-033 i_clear SHALL win over i_start and any byte acceptance: next state IDLE, no write pulse issued for the in-progress word, all counters and outputs to reset values.
REQ-034 o_spad_write_en SHALL never be high for more than one cycle per word.

Reset
REQ-035 On i_nrst low: state IDLE; o_ready, o_spad_write_en, o_busy, o_done =0; o_spad_write_addr, o_spad_data, o_words_written =0; internal counters and pack register =0.
REQ-036 Reset mid-load SHALL discard partial data with no write after release.

Verification
REQ-037 base=0x10, count=16, bytes 0x01..0x10 continuous -> writes addr 0x10 data 0x0807060504030201, addr 0x11 data 0x100F0E0D0C0B0A09, consecutive cycles; o_done=1, o_words_written=2.
REQ-038 base=0x00, count=11, bytes 0xA0..0xAA -> second write data 0x0000000000AAA9A8 at addr 0x01; o_done after FLUSH.
REQ-039 base=0xFF, count=16 -> writes at 0xFF then 0x00 (wrap).
REQ-040 count=0 start -> DONE next cycle, no write, o_words_written=0; i_valid toggled every other cycle on count=8 -> single correct write, one pulse.
REQ-041 i_clear after 5 of 8 bytes -> no write, IDLE, o_ready=0; i_start during FILL ignored; async reset mid-FILL -> all outputs 0.

Source files
------------

// File: rtl/weight_packer.sv
// Packs a stream of weight bytes into scratchpad words, lane 0 first, and writes
// each word one cycle after its last byte is accepted. A final partial word is zero-padded.
module weight_packer #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned DATA_LENGTH     = 8,
    parameter int unsigned SPAD_DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH      = 8,
    localparam int unsigned CNT_WIDTH      = ADDR_WIDTH + $clog2(DATA_LENGTH)
) (
    input  logic                       i_clk,
    input  logic                       i_nrst,
    input  logic                       i_clear,
    input  logic                       i_start,
    input  logic [ADDR_WIDTH-1:0]      i_base_addr,
    input  logic [CNT_WIDTH-1:0]       i_byte_count,
    input  logic                       i_valid,
    input  logic [DATA_WIDTH-1:0]      i_data,
    output logic                       o_ready,
    output logic                       o_spad_write_en,
    output logic [ADDR_WIDTH-1:0]      o_spad_write_addr,
    output logic [SPAD_DATA_WIDTH-1:0] o_spad_data,
    output logic                       o_busy,
    output logic                       o_done,
    output logic [ADDR_WIDTH:0]        o_words_written
);

    localparam int unsigned LANE_WIDTH = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;
    localparam logic [LANE_WIDTH-1:0] LAST_LANE = LANE_WIDTH'(DATA_LENGTH - 1);
    localparam logic [LANE_WIDTH-1:0] LANE_ONE  = LANE_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   WORD_ONE  = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {StIdle, StFill, StFlush, StDone} state_t;

    state_t                     state_q;
    logic [ADDR_WIDTH-1:0]      base_q;
    logic [CNT_WIDTH-1:0]       count_q;
    logic [CNT_WIDTH-1:0]       byte_cnt_q;
    logic [LANE_WIDTH-1:0]      lane_idx_q;
    logic [SPAD_DATA_WIDTH-1:0] pack_q;

    logic                       accept;
    logic                       last_byte;
    logic                       word_end;
    logic [SPAD_DATA_WIDTH-1:0] merged;

    assign o_ready = (state_q == StFill);
    assign o_busy  = (state_q == StFill) || (state_q == StFlush);

    always_comb begin
        accept    = i_valid && (state_q == StFill);
        last_byte = (byte_cnt_q == count_q - CNT_ONE);
        word_end  = (lane_idx_q == LAST_LANE) || last_byte;
        merged    = pack_q;
        merged[lane_idx_q*DATA_WIDTH +: DATA_WIDTH] = i_data;
    end

    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q           <= StIdle;
            base_q            <= '0;
            count_q           <= '0;
            byte_cnt_q        <= '0;
            lane_idx_q        <= '0;
            pack_q            <= '0;
            o_spad_write_en   <= 1'b0;
            o_spad_write_addr <= '0;
            o_spad_data       <= '0;
            o_done            <= 1'b0;
            o_words_written   <= '0;
        end else if (i_clear) begin
            // Abort drops the in-progress word entirely; nothing is written.
            state_q           <= StIdle;
            base_q            <= '0;
            count_q           <= '0;
            byte_cnt_q        <= '0;
            lane_idx_q        <= '0;
            pack_q            <= '0;
            o_spad_write_en   <= 1'b0;
            o_spad_write_addr <= '0;
            o_spad_data       <= '0;
            o_done            <= 1'b0;
            o_words_written   <= '0;
        end else begin
            o_spad_write_en <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (i_start) begin
                        base_q          <= i_base_addr;
                        count_q         <= i_byte_count;
                        byte_cnt_q      <= '0;
                        lane_idx_q      <= '0;
                        pack_q          <= '0;
                        o_words_written <= '0;
                        o_done          <= (i_byte_count == '0);
                        state_q         <= (i_byte_count == '0) ? StDone : StFill;
                    end
                end
                StFill: begin
                    if (accept) begin
                        byte_cnt_q <= byte_cnt_q + CNT_ONE;
                        if (word_end) begin
                            // Word index equals words already written in this load.
                            o_spad_write_en   <= 1'b1;
                            o_spad_data       <= merged;
                            o_spad_write_addr <= base_q + o_words_written[ADDR_WIDTH-1:0];
                            o_words_written   <= o_words_written + WORD_ONE;
                            pack_q            <= '0;
                            lane_idx_q        <= '0;
                            if (last_byte) begin
                                state_q <= StFlush;
                            end
                        end else begin
                            pack_q     <= merged;
                            lane_idx_q <= lane_idx_q + LANE_ONE;
                        end
                    end
                end
                StFlush: begin
                    state_q <= StDone;
                    o_done  <= 1'b1;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_weight_packer.sv
// Randomized scoreboard bench for weight_packer: the driver pushes expected scratchpad
// writes (address, data, due cycle) and a negedge monitor pops and compares them.
module tb_weight_packer;

    localparam int DW = 8;
    localparam int DL = 8;
    localparam int SW = 64;
    localparam int AW = 8;
    localparam int CW = AW + $clog2(DL);

    logic          i_clk = 1'b0;
    logic          i_nrst = 1'b0;
    logic          i_clear = 1'b0;
    logic          i_start = 1'b0;
    logic [AW-1:0] i_base_addr = '0;
    logic [CW-1:0] i_byte_count = '0;
    logic          i_valid = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          o_ready;
    logic          o_spad_write_en;
    logic [AW-1:0] o_spad_write_addr;
    logic [SW-1:0] o_spad_data;
    logic          o_busy;
    logic          o_done;
    logic [AW:0]   o_words_written;

    weight_packer #(
        .DATA_WIDTH(DW),
        .DATA_LENGTH(DL),
        .SPAD_DATA_WIDTH(SW),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk(i_clk),
        .i_nrst(i_nrst),
        .i_clear(i_clear),
        .i_start(i_start),
        .i_base_addr(i_base_addr),
        .i_byte_count(i_byte_count),
        .i_valid(i_valid),
        .i_data(i_data),
        .o_ready(o_ready),
        .o_spad_write_en(o_spad_write_en),
        .o_spad_write_addr(o_spad_write_addr),
        .o_spad_data(o_spad_data),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_words_written(o_words_written)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [SW-1:0] data;
        int            due;
    } wr_t;

    wr_t sb[$];
    int  total = 0;
    int  bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write strobe must match the oldest outstanding expectation.
    always @(negedge i_clk) begin
        wr_t e;
        if (o_spad_write_en === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h, want no write (cycle %0d)",
                         o_spad_write_addr, o_spad_data, cyc);
            end else begin
                e = sb.pop_front();
                chk("wr_addr", 64'(o_spad_write_addr), 64'(e.addr));
                chk("wr_data", o_spad_data, e.data);
                chk("wr_cycle", 64'(cyc), 64'(e.due));
            end
        end
    end

    // Reference: word w holds bytes w*DL.. in ascending lanes, address wraps mod 2^AW.
    task automatic push_word(input logic [AW-1:0] base, input logic [7:0] b[$], input int last,
                             input int due);
        wr_t e;
        int  w;
        int  first;
        w      = last / DL;
        first  = w * DL;
        e.data = '0;
        for (int j = first; j <= last; j++) begin
            e.data = e.data | (64'(b[j]) << (8 * (j - first)));
        end
        e.addr = AW'((int'(base) + w) % (1 << AW));
        e.due  = due;
        sb.push_back(e);
    endtask

    // mode: 0 continuous, 1 valid every other cycle, 2 random valid
    task automatic run_load(input logic [AW-1:0] base, input int count, input int seq,
                            input int mode, input bit poke_start);
        logic [7:0] b[$];
        int         i;
        int         guard;
        bit         v;
        for (int k = 0; k < count; k++) begin
            b.push_back((seq < 0) ? 8'($urandom) : 8'((seq + k) & 8'hFF));
        end
        i_base_addr  = base;
        i_byte_count = CW'(count);
        i_start      = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        if (count == 0) begin
            chk("zero_done", 64'(o_done), 64'd1);
            chk("zero_busy", 64'(o_busy), 64'd0);
            chk("zero_ready", 64'(o_ready), 64'd0);
            chk("zero_words", 64'(o_words_written), 64'd0);
            return;
        end
        chk("start_done_clr", 64'(o_done), 64'd0);
        chk("start_busy", 64'(o_busy), 64'd1);
        i     = 0;
        guard = 0;
        while (i < count && guard < 4 * count + 20) begin
            case (mode)
                0:       v = 1'b1;
                1:       v = (guard % 2) == 0;
                default: v = $urandom_range(0, 99) < 60;
            endcase
            i_valid = v;
            i_data  = b[i];
            if (poke_start && i == 3) begin
                i_start      = 1'b1;
                i_base_addr  = ~base;
                i_byte_count = CW'(5);
            end else begin
                i_start = 1'b0;
            end
            if (v && o_ready === 1'b1) begin
                if ((i % DL) == DL - 1 || i == count - 1) push_word(base, b, i, cyc + 1);
                i++;
            end
            @(posedge i_clk);
            #1;
            guard++;
        end
        i_valid = 1'b0;
        i_start = 1'b0;
        if (i < count) begin
            total++;
            bad++;
            $display("FAIL feed_timeout: got %0d bytes accepted, want %0d", i, count);
        end
        if (mode == 0) chk("no_bubble_cycles", 64'(guard), 64'(count));
        chk("flush_ready", 64'(o_ready), 64'd0);
        chk("flush_busy", 64'(o_busy), 64'd1);
        chk("flush_done", 64'(o_done), 64'd0);
        @(posedge i_clk);
        #1;
        chk("done", 64'(o_done), 64'd1);
        chk("done_busy", 64'(o_busy), 64'd0);
        chk("words", 64'(o_words_written), 64'((count + DL - 1) / DL));
        repeat (2) @(posedge i_clk);
        #1;
        chk("done_hold", 64'(o_done), 64'd1);
        chk("words_hold", 64'(o_words_written), 64'((count + DL - 1) / DL));
    endtask

    // Feed n bytes of a load that never completes a word (n < DL).
    task automatic feed_partial(input logic [AW-1:0] base, input int count, input int n);
        i_base_addr  = base;
        i_byte_count = CW'(count);
        i_start      = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int k = 0; k < n; k++) begin
            i_valid = 1'b1;
            i_data  = 8'($urandom);
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'd0);
        chk({tag, "_we"}, 64'(o_spad_write_en), 64'd0);
        chk({tag, "_addr"}, 64'(o_spad_write_addr), 64'd0);
        chk({tag, "_data"}, o_spad_data, 64'd0);
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_done"}, 64'(o_done), 64'd0);
        chk({tag, "_words"}, 64'(o_words_written), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk_all_zero("reset");
        #10;
        i_nrst = 1'b1;
        @(posedge i_clk);
        #1;

        run_load(8'h10, 16, 1, 0, 1'b0);
        run_load(8'h00, 11, 8'hA0, 0, 1'b0);
        run_load(8'hFF, 16, -1, 0, 1'b0);
        run_load(8'h33, 0, -1, 0, 1'b0);
        repeat (3) @(posedge i_clk);
        #1;
        chk("zero_no_write_words", 64'(o_words_written), 64'd0);
        run_load(8'h20, 8, -1, 1, 1'b0);
        run_load(8'h80, 20, -1, 2, 1'b1);

        // Clear beats a simultaneous start and byte acceptance.
        feed_partial(8'h40, 8, 5);
        i_clear      = 1'b1;
        i_start      = 1'b1;
        i_byte_count = CW'(3);
        i_valid      = 1'b1;
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        i_start = 1'b0;
        i_valid = 1'b0;
        chk_all_zero("clear");
        repeat (4) @(posedge i_clk);
        #1;
        chk("clear_idle_ready", 64'(o_ready), 64'd0);

        for (int n = 0; n < 10; n++) begin
            run_load(AW'($urandom), $urandom_range(1, 40), -1, 2, 1'b0);
        end

        // Asynchronous reset in the middle of a fill.
        feed_partial(8'h55, 16, 4);
        i_nrst  = 1'b0;
        i_valid = 1'b0;
        #2;
        chk_all_zero("async_rst");
        @(negedge i_clk);
        i_nrst = 1'b1;
        repeat (5) @(posedge i_clk);
        #1;
        chk("post_rst_ready", 64'(o_ready), 64'd0);
        chk("post_rst_words", 64'(o_words_written), 64'd0);

        run_load(8'hFE, 19, -1, 2, 1'b0);
        repeat (4) @(posedge i_clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
